// File: rtl/uncached_store_buffer.sv
// Posted-write FIFO for uncached stores, drained in order as single-beat AXI writes.
// Define STORE_MERGE_EN to let a store to the word just pushed merge into that entry.
module uncached_store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_strb,
    input  logic [2:0]  st_size,
    input  logic [31:0] ld_addr,
    output logic        ld_hit,
    output logic        empty,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    localparam int CW = PTR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [3:0]       strb_mem [DEPTH];
    logic [2:0]       size_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count;
    state_t           state;
    state_t           state_nxt;
    logic             full;
    logic             push;
    logic             pop;
    logic             merge;
    logic             latch;
    logic             unused_ld_bits;

    assign full = (count == FULL_CNT);

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0] last_ptr;
    logic             merge_ok;

    // With count>=2 the newest entry is valid and is never the head being sent.
    assign last_ptr = wr_ptr - PTR_W'(1);
    assign merge_ok = (count >= CW'(2)) && (addr_mem[last_ptr][31:2] == st_addr[31:2]);
    assign st_ready = !full || merge_ok;
    assign merge    = st_valid && merge_ok;
`else
    assign st_ready = !full;
    assign merge    = 1'b0;
`endif

    assign push  = st_valid && st_ready && !merge;
    assign pop   = (state == RESP) && bvalid;
    assign latch = (state == IDLE) && (count != '0);

    always_ff @(posedge aclk) begin
        if (push) begin
            addr_mem[wr_ptr] <= st_addr;
            data_mem[wr_ptr] <= st_data;
            strb_mem[wr_ptr] <= st_strb;
            size_mem[wr_ptr] <= st_size;
        end
`ifdef STORE_MERGE_EN
        else if (merge) begin
            for (int b = 0; b < 4; b++) begin
                if (st_strb[b]) data_mem[last_ptr][8*b +: 8] <= st_data[8*b +: 8];
            end
            strb_mem[last_ptr] <= strb_mem[last_ptr] | st_strb;
            size_mem[last_ptr] <= 3'd2;
        end
`endif
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count != '0) state_nxt = SEND;
            SEND: if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = RESP;
            RESP: if (bvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // AW and W complete independently; each valid drops on its own handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (latch) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
        end else begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (latch) begin
            awaddr <= addr_mem[rd_ptr];
            awsize <= size_mem[rd_ptr];
            wdata  <= data_mem[rd_ptr];
            wstrb  <= strb_mem[rd_ptr];
        end
    end

    assign awlen  = 4'd0;
    assign wlast  = 1'b1;
    assign bready = (state == RESP);
    assign empty  = (count == '0) && (state == IDLE);

    // The head stays in the valid window until popped, so it keeps flagging hits.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (addr_mem[rd_ptr + PTR_W'(i)][31:2] == ld_addr[31:2]))
                ld_hit = 1'b1;
        end
    end

    assign unused_ld_bits = ^ld_addr[1:0];

endmodule

// File: tb/tb_uncached_store_buffer.sv
// Scoreboard bench for uncached_store_buffer: expected AW/W beats queued at push, checked at handshake.
module tb_uncached_store_buffer;

    localparam int DEPTH = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_strb = '0;
    logic [2:0]  st_size = '0;
    logic [31:0] ld_addr = '0;
    logic        ld_hit;
    logic        empty;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready = 1'b0;
    logic        bvalid = 1'b0;
    logic        bready;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  size;
    } beat_t;

    beat_t exp_aw_q[$];
    beat_t exp_w_q[$];
    int tests = 0;
    int fails = 0;
    int aw_cnt = 0;
    int w_cnt = 0;
    int b_cnt = 0;

    uncached_store_buffer #(.DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .st_strb(st_strb), .st_size(st_size), .ld_addr(ld_addr), .ld_hit(ld_hit), .empty(empty),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    // Monitor: handshakes are sampled on the falling edge, ahead of the rising edge that completes them.
    initial begin
        beat_t e;
        logic aw_hold = 1'b0;
        logic w_hold = 1'b0;
        logic [34:0] aw_held = '0;
        logic [35:0] w_held = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                aw_hold = 1'b0;
                w_hold = 1'b0;
            end else begin
                if (aw_hold) begin
                    tests++;
                    if (awvalid !== 1'b1 || {awaddr, awsize} !== aw_held) begin
                        fails++;
                        $display("FAIL aw_stable: awvalid=%b awaddr=%h required awvalid=1 awaddr=%h", awvalid, awaddr, aw_held[34:3]);
                    end
                end
                if (w_hold) begin
                    tests++;
                    if (wvalid !== 1'b1 || {wdata, wstrb} !== w_held) begin
                        fails++;
                        $display("FAIL w_stable: wvalid=%b wdata=%h required wvalid=1 wdata=%h", wvalid, wdata, w_held[35:4]);
                    end
                end
                if (awvalid && awready) begin
                    aw_cnt++;
                    tests++;
                    if (exp_aw_q.size() == 0) begin
                        fails++;
                        $display("FAIL aw_unexpected: awaddr=%h required no beat", awaddr);
                    end else begin
                        e = exp_aw_q.pop_front();
                        if (awaddr !== e.addr || awsize !== e.size || awlen !== 4'd0) begin
                            fails++;
                            $display("FAIL aw_beat: addr=%h size=%0d len=%0d required addr=%h size=%0d len=0",
                                     awaddr, awsize, awlen, e.addr, e.size);
                        end
                    end
                end
                if (wvalid && wready) begin
                    w_cnt++;
                    tests++;
                    if (exp_w_q.size() == 0) begin
                        fails++;
                        $display("FAIL w_unexpected: wdata=%h required no beat", wdata);
                    end else begin
                        e = exp_w_q.pop_front();
                        if (wdata !== e.data || wstrb !== e.strb || wlast !== 1'b1) begin
                            fails++;
                            $display("FAIL w_beat: data=%h strb=%b last=%b required data=%h strb=%b last=1",
                                     wdata, wstrb, wlast, e.data, e.strb);
                        end
                    end
                end
                if (bvalid && bready) b_cnt++;
                aw_hold = awvalid && !awready;
                w_hold  = wvalid && !wready;
                aw_held = {awaddr, awsize};
                w_held  = {wdata, wstrb};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] sz, input bit expect_beat);
        int n = 0;
        st_valid = 1'b1; st_addr = a; st_data = d; st_strb = s; st_size = sz;
        #1;
        while (st_ready !== 1'b1 && n < 100) begin
            @(posedge aclk);
            #2;
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL push_timeout: addr=%h st_ready=%b required 1", a, st_ready);
        end else if (expect_beat) begin
            exp_aw_q.push_back('{a, d, s, sz});
            exp_w_q.push_back('{a, d, s, sz});
        end
        tick();
        st_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget, output int cycles);
        cycles = 0;
        while (empty !== 1'b1 && cycles < budget) begin
            tick();
            cycles++;
        end
        tests++;
        if (empty !== 1'b1) begin
            fails++;
            $display("FAIL drain_timeout: empty=%b after %0d cycles required 1", empty, cycles);
        end
    endtask

    task automatic test_reset();
        tests++;
        if ({awvalid, wvalid, bready, ld_hit, empty, st_ready} !== 6'b000011) begin
            fails++;
            $display("FAIL reset_in: aw/w/b/hit/empty/ready=%b required 000011",
                     {awvalid, wvalid, bready, ld_hit, empty, st_ready});
        end
        aresetn = 1'b1;
        tick();
        tick();
        tests++;
        if ({awvalid, wvalid, bready, ld_hit, empty, st_ready} !== 6'b000011) begin
            fails++;
            $display("FAIL reset_out: aw/w/b/hit/empty/ready=%b required 000011",
                     {awvalid, wvalid, bready, ld_hit, empty, st_ready});
        end
    endtask

    task automatic test_single();
        int aw0 = aw_cnt, w0 = w_cnt, b0 = b_cnt, cyc;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        push(32'h1FAF_0000, 32'hDEAD_BEEF, 4'hF, 3'd2, 1'b1);
        tests++;
        if (empty !== 1'b0) begin
            fails++;
            $display("FAIL single_busy: empty=%b required 0", empty);
        end
        wait_empty(10, cyc);
        tests++;
        if (cyc > 5) begin
            fails++;
            $display("FAIL single_latency: cycles=%0d required <=5", cyc);
        end
        repeat (3) tick();
        tests++;
        if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || b_cnt - b0 != 1) begin
            fails++;
            $display("FAIL single_beats: aw=%0d w=%0d b=%0d required 1 1 1", aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
        end
    endtask

    task automatic test_fill();
        int aw0 = aw_cnt, n = 0, cyc;
        awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
        for (int i = 0; i < 4; i++)
            push(32'h1FAF_0100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 3'd2, 1'b1);
        st_valid = 1'b1; st_addr = 32'h1FAF_0110; st_data = 32'hA000_0004; st_strb = 4'hF; st_size = 3'd2;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (st_ready !== 1'b0) begin
                fails++;
                $display("FAIL fill_full: st_ready=%b required 0 (wait %0d)", st_ready, i);
            end
            tick();
        end
        awready = 1'b1;
        #1;
        while (st_ready !== 1'b1 && n < 50) begin
            @(posedge aclk);
            #2;
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL fill_release: st_ready=%b required 1", st_ready);
        end else begin
            exp_aw_q.push_back('{32'h1FAF_0110, 32'hA000_0004, 4'hF, 3'd2});
            exp_w_q.push_back('{32'h1FAF_0110, 32'hA000_0004, 4'hF, 3'd2});
        end
        tick();
        st_valid = 1'b0;
        wait_empty(100, cyc);
        tests++;
        if (aw_cnt - aw0 != 5) begin
            fails++;
            $display("FAIL fill_count: aw beats=%0d required 5", aw_cnt - aw0);
        end
    endtask

    task automatic test_independent();
        int aw0, w0, b0, cyc;
        for (int k = 0; k < 2; k++) begin
            aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
            awready = (k == 1); wready = (k == 0); bvalid = 1'b1;
            push(32'h1FAF_0200 + 32'(k * 4), 32'h5A5A_0000 + 32'(k), 4'b1100, 3'd1, 1'b1);
            repeat (4) tick();
            tests++;
            if (awvalid !== (k == 0) || wvalid !== (k == 1) || bready !== 1'b0) begin
                fails++;
                $display("FAIL indep_wait%0d: awvalid=%b wvalid=%b bready=%b required %b %b 0",
                         k, awvalid, wvalid, bready, (k == 0), (k == 1));
            end
            awready = 1'b1; wready = 1'b1;
            wait_empty(20, cyc);
            repeat (2) tick();
            tests++;
            if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || b_cnt - b0 != 1) begin
                fails++;
                $display("FAIL indep_beats%0d: aw=%0d w=%0d b=%0d required 1 1 1", k, aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
            end
        end
    endtask

    task automatic test_hazard();
        int cyc;
        awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
        ld_addr = 32'h1FAF_F00A;
        st_valid = 1'b1; st_addr = 32'h1FAF_F008; st_data = 32'h0000_00C3; st_strb = 4'h1; st_size = 3'd0;
        #1;
        tests++;
        if (ld_hit !== 1'b0 || st_ready !== 1'b1) begin
            fails++;
            $display("FAIL hazard_same_cycle: ld_hit=%b st_ready=%b required 0 1", ld_hit, st_ready);
        end
        exp_aw_q.push_back('{32'h1FAF_F008, 32'h0000_00C3, 4'h1, 3'd0});
        exp_w_q.push_back('{32'h1FAF_F008, 32'h0000_00C3, 4'h1, 3'd0});
        tick();
        st_valid = 1'b0;
        #1;
        tests++;
        if (ld_hit !== 1'b1) begin
            fails++;
            $display("FAIL hazard_pending: ld_hit=%b required 1", ld_hit);
        end
        ld_addr = 32'h1FAF_F00C;
        #1;
        tests++;
        if (ld_hit !== 1'b0) begin
            fails++;
            $display("FAIL hazard_other_word: ld_hit=%b required 0", ld_hit);
        end
        ld_addr = 32'h1FAF_F00A;
        repeat (3) tick();
        tests++;
        if (ld_hit !== 1'b1) begin
            fails++;
            $display("FAIL hazard_in_flight: ld_hit=%b required 1", ld_hit);
        end
        awready = 1'b1;
        wait_empty(20, cyc);
        tests++;
        if (ld_hit !== 1'b0) begin
            fails++;
            $display("FAIL hazard_cleared: ld_hit=%b required 0", ld_hit);
        end
        ld_addr = '0;
    endtask

    task automatic test_reset_mid();
        int n = 0, aw0, cyc;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        push(32'h1FAF_0300, 32'h0BAD_F00D, 4'hF, 3'd2, 1'b0);
        while (awvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
            fails++;
            $display("FAIL midrst_send: awvalid=%b wvalid=%b required 1 1", awvalid, wvalid);
        end
        #2;
        aresetn = 1'b0;
        #1;
        tests++;
        if ({awvalid, wvalid, bready, empty, st_ready} !== 5'b00011) begin
            fails++;
            $display("FAIL midrst_clear: aw/w/b/empty/ready=%b required 00011", {awvalid, wvalid, bready, empty, st_ready});
        end
        repeat (2) tick();
        aresetn = 1'b1;
        tick();
        awready = 1'b1; wready = 1'b1;
        aw0 = aw_cnt;
        push(32'h1FAF_0304, 32'h1234_5678, 4'hF, 3'd2, 1'b1);
        wait_empty(20, cyc);
        tests++;
        if (aw_cnt - aw0 != 1) begin
            fails++;
            $display("FAIL midrst_after: aw beats=%0d required 1", aw_cnt - aw0);
        end
    endtask

`ifdef STORE_MERGE_EN
    task automatic test_merge();
        int aw0 = aw_cnt, cyc;
        awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
        push(32'h0000_2000, 32'h0000_0055, 4'hF, 3'd2, 1'b1);
        push(32'h0000_1000, 32'h0000_0011, 4'b0001, 3'd0, 1'b0);
        push(32'h0000_1000, 32'h0000_2200, 4'b0010, 3'd0, 1'b0);
        exp_aw_q.push_back('{32'h0000_1000, 32'h0000_2211, 4'b0011, 3'd2});
        exp_w_q.push_back('{32'h0000_1000, 32'h0000_2211, 4'b0011, 3'd2});
        awready = 1'b1;
        wait_empty(40, cyc);
        tests++;
        if (aw_cnt - aw0 != 2) begin
            fails++;
            $display("FAIL merge_count: aw beats=%0d required 2", aw_cnt - aw0);
        end
    endtask
`endif

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        test_reset();
        test_single();
        test_fill();
        test_independent();
        test_hazard();
        test_reset_mid();
`ifdef STORE_MERGE_EN
        test_merge();
`endif
        repeat (3) tick();
        tests++;
        if (exp_aw_q.size() != 0 || exp_w_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: aw_q=%0d w_q=%0d required 0 0", exp_aw_q.size(), exp_w_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uncached_store_buffer.md
Name: uncached_store_buffer

Overview:
Posted-write buffer between d_cache's uncached store path and the arbitrater's data-side AXI write channels (d_aw*/d_w*/d_b*).
- Accepts single-word uncached stores in one cycle and releases the pipeline immediately.
- Drains entries in order as single-beat AXI writes.
- Flags loads that hit a pending store, so d_cache can stall them until the store is drained.

Parameters:
DEPTH, 4, number of entries; must be a power of 2, ≥2.
PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
st_valid  in  1  store request from d_cache
st_ready  out  1  buffer can accept (not full)
st_addr  in  32  physical byte address
st_data  in  32  store data, lane-aligned
st_strb  in  4  byte enables
st_size  in  3  AXI size code (0/1/2)
ld_addr  in  32  physical address of uncached load in MEM
ld_hit  out  1  a valid entry matches ld_addr[31:2]
empty  out  1  no entries and no write in flight
awaddr  out  32  to arbitrater d_awaddr
awlen  out  4  always 0
awsize  out  3  head entry size
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  head data
wstrb  out  4  head strobes
wlast  out  1  always 1 when wvalid
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Reset (async, aresetn=0):
  - Pointers, count and FSM cleared; FSM enters IDLE.
  - All AXI valids=0, bready=0, ld_hit=0, empty=1, st_ready=1.
  - Asserting reset mid-burst abandons the transaction; there is no recovery handshake.
- Push: accepted when st_valid && st_ready. Entry written at tail; count+1 in the following cycle.
- st_ready = (count != DEPTH). Not dependent on st_valid.
- Drain FSM:
  - IDLE: if count>0, latch head into output regs and go to SEND. Next cycle awvalid=wvalid=1.
  - SEND: awvalid drops after the AW handshake, wvalid drops after the W handshake. The two channels complete independently, in either order or in the same cycle. When both are done, go to RESP.
  - RESP: bready=1. On bvalid, pop head (rd_ptr+1, count-1) and go to IDLE. bresp is ignored.
  - Minimum head-to-head turnaround is 3 cycles with zero-wait slaves. IDLE→SEND needs ≥1 cycle after the pop.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Push while full is refused (st_ready=0). The cycle the pop occurs, st_ready is still 0; it rises the next cycle.
- Pointers wrap modulo DEPTH. count is PTR_W+1 bits so full and empty are distinguishable.
- ld_hit:
  - Combinational OR over all valid entries of (entry.addr[31:2]==ld_addr[31:2]).
  - The in-flight head counts as valid until popped.
  - A same-cycle push is not visible; d_cache must stall one cycle after a push.
- empty = (count==0) && FSM==IDLE.
- AXI outputs are registered; they are stable while valid is high and not yet accepted.

Optional Feature:
STORE_MERGE_EN
- Defined: a push whose addr[31:2] equals the most recently pushed entry merges into that entry, provided:
  - the entry is valid, and
  - it is not the head latched in SEND/RESP.
- Merge behaviour:
  - Bytes where st_strb=1 overwrite data; strb is OR-ed; size is forced to 2.
  - No new entry is allocated and count is unchanged.
  - Merge is allowed even when full; st_ready = !full || merge_possible.
- Undefined: every push allocates a new entry. The merge compare logic is absent.

Test Plan:
- Single store: push addr 0x1FAF_0000, data 0xDEADBEEF, strb F; awready=wready=bvalid=1 → exactly one AW and one W beat (awaddr 0x1FAF_0000, wlast=1, awlen=0); empty returns to 1 within 5 cycles.
- Fill and backpressure: hold awready=0, push 5 stores (DEPTH=4) → st_ready=0 after the 4th push; the 5th is held. Release awready → drain order 0,1,2,3,4 by address.
- Independent channels: W accepted 3 cycles before AW, and the reverse ordering → one B handshake per entry, no duplicate beats, valids stable until accepted.
- Hazard: pending store to 0x1FAF_F008, ld_addr 0x1FAF_F00A → ld_hit=1; after B accepted → ld_hit=0. ld_addr 0x1FAF_F00C → ld_hit=0 throughout.
- Reset mid-SEND: deassert aresetn while awvalid=1 → awvalid/wvalid 0 immediately, empty=1; a new push afterwards drains normally.
- STORE_MERGE_EN: with head stalled, push 0x1000 strb 0001 data 0x11, then 0x1000 strb 0010 data 0x2200 → one W beat, wstrb 0011, wdata[15:0]=0x2211.
